// File: rtl/echo_capture_pkg.sv
// Shared definitions for the multi-channel echo capture block.
package echo_capture_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_RISE = 2'd0,
    ST_HIGH      = 2'd1,
    ST_DONE      = 2'd2,
    ST_TIMED_OUT = 2'd3
  } chan_state_e;

endpackage

// File: rtl/echo_channel.sv
// One echo measurement channel: captures rise time and pulse width against
// an external wrapping timer, with a per-arm timeout.
module echo_channel
  import echo_capture_pkg::*;
#(
  parameter int unsigned WIDTH         = 13,
  parameter int unsigned TIMEOUT_TICKS = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] timer,
  input  logic             echo,
  input  logic             arm,
  output logic [WIDTH-1:0] echo_time,
  output logic [WIDTH-1:0] echo_width,
  output logic             done,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] TIMEOUT_VAL = WIDTH'(TIMEOUT_TICKS);

  chan_state_e      r_state;
  logic             r_echo_q;
  logic [WIDTH-1:0] r_arm_stamp;
  logic [WIDTH-1:0] r_time;
  logic [WIDTH-1:0] r_width;
  logic             r_done;
  logic             r_timeout;

  logic             w_rise;
  logic             w_fall;
  logic [WIDTH-1:0] w_elapsed;
  logic             w_expired;

  assign w_rise    = echo & ~r_echo_q;
  assign w_fall    = ~echo & r_echo_q;
  // Modular subtraction keeps elapsed and width correct across timer wrap.
  assign w_elapsed = timer - r_arm_stamp;
  assign w_expired = (w_elapsed == TIMEOUT_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_WAIT_RISE;
      r_echo_q    <= 1'b0;
      r_arm_stamp <= timer;
      r_time      <= '0;
      r_width     <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_echo_q <= echo;
      if (arm) begin
        r_state     <= ST_WAIT_RISE;
        r_arm_stamp <= timer;
        r_time      <= '0;
        r_width     <= '0;
        r_done      <= 1'b0;
        r_timeout   <= 1'b0;
      end else begin
        case (r_state)
          ST_WAIT_RISE: begin
            if (w_expired) begin
              r_timeout <= 1'b1;
              r_state   <= ST_TIMED_OUT;
            end else if (w_rise) begin
              r_time  <= timer;
              r_state <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (w_expired) begin
              r_timeout <= 1'b1;
              r_state   <= ST_TIMED_OUT;
            end else if (w_fall) begin
              r_width <= timer - r_time;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
          ST_DONE:      r_state <= ST_DONE;
          ST_TIMED_OUT: r_state <= ST_TIMED_OUT;
          default:      r_state <= ST_WAIT_RISE;
        endcase
      end
    end
  end

  assign echo_time  = r_time;
  assign echo_width = r_width;
  assign done       = r_done;
  assign timeout    = r_timeout;

endmodule

// File: rtl/echo_capture_multi.sv
// Multi-channel echo capture: CHANNELS independent echo_channel instances
// sharing one timer, with outputs packed WIDTH bits per channel.
module echo_capture_multi
  import echo_capture_pkg::*;
#(
  parameter int unsigned WIDTH         = 13,
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned TIMEOUT_TICKS = 4000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          timer,
  input  logic [CHANNELS-1:0]       echo,
  input  logic [CHANNELS-1:0]       arm,
  output logic [CHANNELS*WIDTH-1:0] echo_time,
  output logic [CHANNELS*WIDTH-1:0] echo_width,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       timeout
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    echo_channel #(
      .WIDTH        (WIDTH),
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .timer     (timer),
      .echo      (echo[g]),
      .arm       (arm[g]),
      .echo_time (echo_time[g*WIDTH +: WIDTH]),
      .echo_width(echo_width[g*WIDTH +: WIDTH]),
      .done      (done[g]),
      .timeout   (timeout[g])
    );
  end

endmodule

// File: tb/tb_echo_capture_multi.sv
// Self-checking bench for echo_capture_multi: per-cycle reference model
// comparison plus directed scenarios with literal expectations.
module tb_echo_capture_multi;

  localparam int unsigned W  = 13;
  localparam int unsigned C  = 4;
  localparam int unsigned TO = 4000;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   timer;
  logic [C-1:0]   echo;
  logic [C-1:0]   arm;
  logic [C*W-1:0] echo_time;
  logic [C*W-1:0] echo_width;
  logic [C-1:0]   done;
  logic [C-1:0]   timeout;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          sim_done = 1'b0;

  // Reference model state, one entry per channel.
  logic [W-1:0] m_time  [C];
  logic [W-1:0] m_width [C];
  logic [W-1:0] m_stamp [C];
  bit           m_done  [C];
  bit           m_to    [C];
  bit           m_seen  [C];
  bit           m_prev  [C];

  echo_capture_multi #(
    .WIDTH        (W),
    .CHANNELS     (C),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .timer     (timer),
    .echo      (echo),
    .arm       (arm),
    .echo_time (echo_time),
    .echo_width(echo_width),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] sl(input logic [C*W-1:0] v, input int unsigned i);
    return v[i*W +: W];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Measurement rules: after arm/reset a channel waits for a rising edge,
  // then a falling edge; it gives up when exactly TO ticks have elapsed.
  task automatic model_step();
    logic [W-1:0] el;
    for (int unsigned i = 0; i < C; i++) begin
      if (reset) begin
        m_time[i] = '0; m_width[i] = '0; m_done[i] = 0; m_to[i] = 0;
        m_seen[i] = 0;  m_stamp[i] = timer; m_prev[i] = 0;
      end else begin
        if (arm[i]) begin
          m_time[i] = '0; m_width[i] = '0; m_done[i] = 0; m_to[i] = 0;
          m_seen[i] = 0;  m_stamp[i] = timer;
        end else if (!m_done[i] && !m_to[i]) begin
          el = timer - m_stamp[i];
          if (el == W'(TO)) m_to[i] = 1;
          else if (!m_seen[i] && echo[i] && !m_prev[i]) begin
            m_seen[i] = 1; m_time[i] = timer;
          end else if (m_seen[i] && !echo[i] && m_prev[i]) begin
            m_width[i] = timer - m_time[i]; m_done[i] = 1;
          end
        end
        m_prev[i] = echo[i];
      end
    end
  endtask

  initial begin
    while (!sim_done) begin
      @(posedge clk);
      model_step();
      #1;
      for (int unsigned i = 0; i < C; i++) begin
        check($sformatf("model ch%0d echo_time", i), 64'(sl(echo_time, i)), 64'(m_time[i]));
        check($sformatf("model ch%0d echo_width", i), 64'(sl(echo_width, i)), 64'(m_width[i]));
        check($sformatf("model ch%0d done", i), 64'(done[i]), 64'(m_done[i]));
        check($sformatf("model ch%0d timeout", i), 64'(timeout[i]), 64'(m_to[i]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    timer = timer + 1'b1;
  endtask

  task automatic wait_timer(input logic [W-1:0] t);
    int unsigned guard = 0;
    while (timer != t && guard < 9000) begin
      tick();
      guard++;
    end
    if (timer != t) begin
      n_total++;
      $display("FAIL wait_timer: got %0d expected %0d", timer, t);
    end
  endtask

  initial begin
    timer = '0; reset = 1'b1; echo = '0; arm = '0;
    tick();
    reset = 1'b0;

    // No echo: idle until exactly TO ticks after reset.
    wait_timer(13'd4000);
    check("idle timeout", 64'(timeout), 64'(0));
    check("idle done", 64'(done), 64'(0));
    check("idle echo_time", 64'(echo_time), 64'(0));
    tick();
    check("expiry timeout", 64'(timeout), 64'(4'b1111));
    check("expiry done", 64'(done), 64'(0));

    wait_timer(13'd8000);
    arm = 4'b1111;
    tick();
    arm = '0;
    check("rearm timeout", 64'(timeout), 64'(0));

    // ch1 pulse straddling timer wrap.
    wait_timer(13'd8190); echo[1] = 1'b1;
    wait_timer(13'd3);    echo[1] = 1'b0;
    tick();
    check("ch1 time", 64'(sl(echo_time, 1)), 64'(8190));
    check("ch1 width", 64'(sl(echo_width, 1)), 64'(5));
    check("ch1 done", 64'(done[1]), 64'(1));

    wait_timer(13'd100); echo[0] = 1'b1;
    wait_timer(13'd200); echo[2] = 1'b1;
    wait_timer(13'd300); echo[2] = 1'b0;
    wait_timer(13'd350); echo[0] = 1'b0;
    tick();
    check("ch0 time", 64'(sl(echo_time, 0)), 64'(100));
    check("ch0 width", 64'(sl(echo_width, 0)), 64'(250));
    check("done vec", 64'(done), 64'(4'b0111));
    check("ch3 untouched", 64'(sl(echo_time, 3)), 64'(0));

    // ch2 ignores edges once done, then re-arms and measures again.
    wait_timer(13'd400); echo[2] = 1'b1;
    wait_timer(13'd420); echo[2] = 1'b0;
    tick();
    check("ch2 held time", 64'(sl(echo_time, 2)), 64'(200));
    check("ch2 held width", 64'(sl(echo_width, 2)), 64'(100));
    wait_timer(13'd450); arm[2] = 1'b1;
    tick();
    arm = '0;
    check("ch2 arm time", 64'(sl(echo_time, 2)), 64'(0));
    check("ch2 arm width", 64'(sl(echo_width, 2)), 64'(0));
    check("ch2 arm done", 64'(done[2]), 64'(0));
    wait_timer(13'd500); echo[2] = 1'b1;
    wait_timer(13'd520); echo[2] = 1'b0;
    tick();
    check("ch2 new time", 64'(sl(echo_time, 2)), 64'(500));
    check("ch2 new width", 64'(sl(echo_width, 2)), 64'(20));

    // arm and rise on ch3 in the same cycle: the rise is lost.
    wait_timer(13'd600); echo[3] = 1'b1; arm[3] = 1'b1;
    tick();
    arm = '0;
    check("ch3 arm+rise time", 64'(sl(echo_time, 3)), 64'(0));
    wait_timer(13'd700); echo[3] = 1'b0;
    tick();
    check("ch3 no done", 64'(done[3]), 64'(0));
    check("ch3 width", 64'(sl(echo_width, 3)), 64'(0));

    // Reset while ch0 is mid-pulse; the pulse ends during reset.
    wait_timer(13'd1000); arm[0] = 1'b1;
    tick();
    arm = '0;
    wait_timer(13'd1100); echo[0] = 1'b1;
    wait_timer(13'd1150);
    check("ch0 high time", 64'(sl(echo_time, 0)), 64'(1100));
    check("ch0 high done", 64'(done[0]), 64'(0));
    wait_timer(13'd1200); reset = 1'b1;
    tick();
    echo[0] = 1'b0;
    tick();
    reset = 1'b0;
    check("reset time", 64'(echo_time), 64'(0));
    check("reset width", 64'(echo_width), 64'(0));
    check("reset done", 64'(done), 64'(0));
    wait_timer(13'd1300);
    check("post reset done", 64'(done[0]), 64'(0));

    // Timeout measured from the last reset cycle (timer 1201).
    wait_timer(13'd5201);
    check("late idle timeout", 64'(timeout), 64'(0));
    tick();
    check("late timeout", 64'(timeout), 64'(4'b1111));
    check("late done", 64'(done), 64'(0));

    sim_done = 1'b1;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/echo_capture_multi.md
ECHO_CAPTURE_MULTI -- requirements
Module: echo_capture_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 13, bit width of the timer and all time outputs.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent echo inputs.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 4000, elapsed ticks after arm at which an unanswered channel gives up.
REQ-004 SHALL have port clk  input  1  one clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port timer  input  WIDTH  free-running external time base, wraps modulo 2^WIDTH.
REQ-007 SHALL have port echo  input  CHANNELS  per-channel echo pulse, bit i = channel i.
REQ-008 SHALL have port arm  input  CHANNELS  per-channel one-cycle re-arm request.
REQ-009 SHALL have port echo_time  output  CHANNELS*WIDTH  timer value at first rising echo edge; slice i*WIDTH +: WIDTH = channel i.
REQ-010 SHALL have port echo_width  output  CHANNELS*WIDTH  high-pulse duration in timer ticks, same slicing.
REQ-011 SHALL have port done  output  CHANNELS  channel holds a complete measurement.
REQ-012 SHALL have port timeout  output  CHANNELS  channel timed out without a complete measurement.

Function
REQ-013 SHALL keep one registered echo sample per channel (echo_q) and define rise = echo & ~echo_q, fall = ~echo & echo_q at each clock edge.
REQ-014 SHALL run one FSM per channel, states WAIT_RISE, HIGH, DONE, TIMED_OUT; channels fully independent.
REQ-015 SHALL, in WAIT_RISE on rise, register echo_time <= timer and go to HIGH; echo_time visible the cycle after the edge.
REQ-016 SHALL, in HIGH on fall, register echo_width <= (timer - echo_time) mod 2^WIDTH, assert done, go to DONE.
REQ-017 SHALL compute width modulo 2^WIDTH so a pulse straddling timer wrap (e.g. rise at 8190, fall at 3) yields 5.
REQ-018 SHALL hold echo_time, echo_width, done in DONE and ignore all further echo edges until arm or reset.
REQ-019 SHALL record arm_stamp <= timer on reset and on arm; elapsed = (timer - arm_stamp) mod 2^WIDTH.
REQ-020 SHALL, in WAIT_RISE or HIGH when elapsed == TIMEOUT_TICKS, assert timeout, go to TIMED_OUT; echo_time retains any captured rise value, echo_width stays 0.
REQ-021 SHALL hold TIMED_OUT until arm or reset; done and timeout never both high.
REQ-022 SHALL, on arm[i] in any state, clear channel i echo_time, echo_width, done, timeout to 0 and enter WAIT_RISE next cycle.
REQ-023 SHALL give arm priority over a rise, fall or timeout in the same cycle; that edge is not captured.
REQ-024 SHALL treat a rise and timeout condition in the same WAIT_RISE cycle as timeout (timeout priority over capture).
REQ-025 SHALL update echo_q every cycle in every state including the arm cycle, so an echo already high at arm does not produce a rise.

Reset
REQ-026 SHALL, on reset, set all echo_time, echo_width to 0, done and timeout to 0, echo_q to 0, every FSM to WAIT_RISE (armed).
REQ-027 SHALL give reset priority over arm and echo; reset mid-pulse discards the measurement.

Structure
REQ-028 SHALL place the channel state enumeration and state encoding constants in shared package echo_capture_pkg.
REQ-029 SHALL implement one channel as sub-module echo_channel (parameters WIDTH, TIMEOUT_TICKS), instantiated CHANNELS times via generate.
REQ-030 SHALL contain no combinational path from echo or timer to any output; all outputs registered.

Verification (WIDTH=13, CHANNELS=4, TIMEOUT_TICKS=4000, timer incrementing by 1 per clock)
REQ-031 SHALL check: reset then no echo for 3999 cycles -> all outputs 0; at elapsed 4000 -> timeout=4'b1111, done=0.
REQ-032 SHALL check: ch0 echo rises when timer=100, falls when timer=350 -> echo_time[0]=100, echo_width[0]=250, done[0]=1; other channels unaffected.
REQ-033 SHALL check: ch1 rise at timer=8190, fall at timer=3 after arm at 8000 -> echo_width[1]=5, done[1]=1.
REQ-034 SHALL check: ch2 after done, further echo toggles -> values unchanged; arm[2] -> all ch2 outputs 0 next cycle, new pulse 500..520 -> echo_time=500, echo_width=20.
REQ-035 SHALL check: arm[3] asserted on the same cycle as a ch3 rise -> rise ignored, ch3 remains WAIT_RISE with outputs 0.
REQ-036 SHALL check: reset asserted while ch0 in HIGH -> all outputs 0 next cycle, subsequent fall produces no done.
